// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the IF/MEM unified-memory arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;

    // Largest supported RAM latency; the wait counter is sized for it.
    localparam int unsigned LATENCY_MAX = 7;
    localparam int unsigned LAT_W       = $clog2(LATENCY_MAX + 1);

    // Both pending: D wins unless it won last time, so neither side waits behind two grants.
    function automatic grant_t pick_grant(input logic fetch, input logic data, input grant_t last);
        if (fetch && data) begin
            return (last == GNT_D) ? GNT_I : GNT_D;
        end
        return data ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM stages onto one single-ported word RAM with fixed read latency.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW      = 10,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic [31:0]      i_rdata,
    output logic             i_ready,
    output logic             i_stall,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic [31:0]      d_rdata,
    output logic             d_ready,
    output logic             d_err,
    output logic             d_stall,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    arb_state_t       state;
    arb_state_t       next_state;
    grant_t           last_grant;
    grant_t           grant_c;
    logic             take_c;
    logic             d_misal_c;
    logic             conflict_c;
    logic             misal_q;
    logic             we_q;
    logic [LAT_W-1:0] lat_cnt;
    logic [31:0]      rdata_q;
    logic             unused_addr_bits;

    assign i_stall   = i_req & ~i_ready;
    assign d_stall   = d_req & ~d_ready;
    assign d_misal_c = (d_addr[1:0] != 2'b00);

    // Upper address bits alias; fetch byte offset is simply dropped.
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2]};

    // A requester is blocked by the foreign grant, or both contend while idle.
    assign conflict_c = (state == IDLE) ? (i_stall & d_stall)
                      : ((i_stall & (last_grant == GNT_D)) | (d_stall & (last_grant == GNT_I)));

    // Next-state and grant decision.
    always_comb begin
        next_state = state;
        take_c     = 1'b0;
        grant_c    = pick_grant(i_req, d_req, last_grant);
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    take_c     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = misal_q ? DONE : WAIT;
            WAIT:    if (lat_cnt <= LAT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and completion outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
            i_rdata <= 32'h0;
            d_rdata <= 32'h0;
        end else begin
            state   <= next_state;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
            if (state == DONE) begin
                if (last_grant == GNT_I) begin
                    i_ready <= 1'b1;
                    i_rdata <= rdata_q;
                end else begin
                    d_ready <= 1'b1;
                    d_err   <= misal_q;
                    if (!misal_q && !we_q) d_rdata <= rdata_q;
                end
            end
        end
    end

    // Request latch: grant, access attributes and the one-cycle RAM strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_I;
            misal_q    <= 1'b0;
            we_q       <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 32'h0;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
            if (take_c) begin
                last_grant <= grant_c;
                misal_q    <= (grant_c == GNT_D) && d_misal_c;
                we_q       <= (grant_c == GNT_D) && d_we;
                if (grant_c == GNT_I) begin
                    ram_en   <= 1'b1;
                    ram_addr <= i_addr[AW+1:2];
                end else if (!d_misal_c) begin
                    ram_en    <= 1'b1;
                    ram_we    <= d_we;
                    ram_addr  <= d_addr[AW+1:2];
                    ram_wdata <= d_wdata;
                end
            end
        end
    end

    // Latency countdown; read data is captured in the last wait cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
            rdata_q <= 32'h0;
        end else begin
            if (state == ISSUE) begin
                lat_cnt <= LAT_W'(LATENCY);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (state == WAIT && lat_cnt == LAT_W'(1)) rdata_q <= ram_rdata;
        end
    end

    // Saturating contention counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (conflict_c && conflict_cnt != {CNT_W{1'b1}}) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LATENCY=1 and LATENCY=3 with behavioural RAMs.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic preload;

    // LATENCY=1 instance
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, ram_wdata, ram_rdata;
    logic        i_ready, i_stall, d_ready, d_err, d_stall, ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] conflict_cnt;

    mem_port_arbiter #(.AW(10), .LATENCY(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ready(d_ready), .d_err(d_err), .d_stall(d_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    // LATENCY=3 instance
    logic        i_req3, d_req3, d_we3;
    logic [31:0] i_addr3, d_addr3, d_wdata3;
    logic [31:0] i_rdata3, d_rdata3, ram_wdata3, ram_rdata3;
    logic        i_ready3, i_stall3, d_ready3, d_err3, d_stall3, ram_en3, ram_we3;
    logic [9:0]  ram_addr3;
    logic [15:0] conflict_cnt3;

    mem_port_arbiter #(.AW(10), .LATENCY(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_req(i_req3), .i_addr(i_addr3), .i_rdata(i_rdata3), .i_ready(i_ready3), .i_stall(i_stall3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_rdata(d_rdata3),
        .d_ready(d_ready3), .d_err(d_err3), .d_stall(d_stall3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .conflict_cnt(conflict_cnt3)
    );

    // One-cycle-latency RAM; read data is only valid in its single valid cycle.
    logic [31:0] mem1 [0:1023];
    logic        r1_v;
    logic [31:0] r1_d;
    always @(posedge clk) begin
        if (preload) begin
            mem1[1] <= 32'h20080005;
            mem1[2] <= 32'h0000ABCD;
            mem1[9] <= 32'h11111111;
        end else if (ram_en && ram_we) begin
            mem1[ram_addr] <= ram_wdata;
        end
        r1_v <= ram_en && !ram_we;
        r1_d <= mem1[ram_addr];
    end
    assign ram_rdata = r1_v ? r1_d : 32'hDEADBEEF;

    // Three-cycle-latency read-only RAM.
    logic [31:0] mem3 [0:1023];
    logic        v3 [0:2];
    logic [31:0] q3 [0:2];
    always @(posedge clk) begin
        if (preload) begin
            mem3[1] <= 32'h20080005;
            mem3[9] <= 32'h00000055;
        end
        v3[0] <= ram_en3 && !ram_we3;
        q3[0] <= mem3[ram_addr3];
        v3[1] <= v3[0];
        q3[1] <= q3[0];
        v3[2] <= v3[1];
        q3[2] <= q3[1];
    end
    assign ram_rdata3 = v3[2] ? q3[2] : 32'hDEADBEEF;

    // Activity monitors on the LATENCY=1 instance.
    int         en_cnt = 0;
    int         we_cnt = 0;
    int         dr_cnt = 0;
    int         bad_ram_cnt = 0;
    logic [9:0] last_en_addr = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            en_cnt       <= en_cnt + 1;
            last_en_addr <= ram_addr;
        end
        if (ram_we) we_cnt <= we_cnt + 1;
        if (d_ready) dr_cnt <= dr_cnt + 1;
        if (!ram_en && (ram_we || ram_addr != '0 || ram_wdata != 32'h0)) bad_ram_cnt <= bad_ram_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts edges from the sampling edge until the chosen ready; stops at the budget.
    task automatic wait_ready(input bit is_d, input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            @(posedge clk);
            edges++;
            #1;
            if (is_d ? d_ready : i_ready) break;
        end
    endtask

    int e, de, ie, en0, we0, dr0, c0, ncomp;
    int comp_edge [4];
    logic comp_d [4];

    initial begin
        reset = 1'b1; preload = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i_req3 = 0; d_req3 = 0; d_we3 = 0; i_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flags", 32'({i_ready, d_ready, d_err, ram_en, ram_we}), 32'h0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
        check_eq("rst_i_rdata", i_rdata, 32'h0);
        check_eq("rst_d_rdata", d_rdata, 32'h0);
        check_eq("rst_cnt", 32'(conflict_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0; preload = 1'b0;

        // store 7 to byte 0x24
        repeat (2) @(negedge clk);
        en0 = en_cnt; we0 = we_cnt;
        d_we = 1; d_addr = 32'h24; d_wdata = 32'h7; d_req = 1;
        #1 check_eq("st_stall", 32'(d_stall), 32'h1);
        wait_ready(1, 20, e);
        d_req = 0; d_we = 0;
        check_eq("st_lat", e, 4);
        check_eq("st_en_cycles", 32'(en_cnt - en0), 32'h1);
        check_eq("st_we_cycles", 32'(we_cnt - we0), 32'h1);
        check_eq("st_addr", 32'(last_en_addr), 32'h9);
        check_eq("st_err", 32'(d_err), 32'h0);
        check_eq("st_rdata_kept", d_rdata, 32'h0);
        check_eq("st_ram9", mem1[9], 32'h7);

        // fetch word 1
        repeat (2) @(negedge clk);
        dr0 = dr_cnt; en0 = en_cnt;
        i_addr = 32'h4; i_req = 1;
        #1 check_eq("if_stall", 32'(i_stall), 32'h1);
        wait_ready(0, 20, e);
        i_req = 0;
        check_eq("if_lat", e, 4);
        check_eq("if_data", i_rdata, 32'h20080005);
        check_eq("if_no_dready", dr_cnt - dr0, 0);
        check_eq("if_en_cycles", en_cnt - en0, 1);

        // fetch and load rise together
        repeat (2) @(negedge clk);
        c0 = 32'(conflict_cnt);
        i_addr = 32'h8; d_addr = 32'h24; d_we = 0;
        i_req = 1; d_req = 1;
        e = 0; de = 0; ie = 0;
        while (ie == 0 && e < 40) begin
            @(posedge clk);
            e++;
            #1;
            if (d_ready && de == 0) begin de = e; d_req = 0; end
            if (i_ready && ie == 0) begin ie = e; i_req = 0; end
        end
        i_req = 0; d_req = 0;
        check_eq("both_d_lat", de, 4);
        check_eq("both_i_lat", ie, 8);
        check_eq("both_d_data", d_rdata, 32'h7);
        check_eq("both_i_data", i_rdata, 32'h0000ABCD);
        check_eq("both_conflict", 32'(conflict_cnt) - c0, 4);

        // misaligned load
        repeat (2) @(negedge clk);
        en0 = en_cnt;
        d_addr = 32'h26; d_we = 0; d_req = 1;
        wait_ready(1, 20, e);
        d_req = 0;
        check_eq("mis_lat", e, 3);
        check_eq("mis_err", 32'(d_err), 32'h1);
        check_eq("mis_no_en", en_cnt - en0, 0);
        check_eq("mis_ram9", mem1[9], 32'h7);
        check_eq("mis_rdata_kept", d_rdata, 32'h7);

        // LATENCY=3, both held: alternating completions
        repeat (2) @(negedge clk);
        c0 = 32'(conflict_cnt3);
        i_addr3 = 32'h4; d_addr3 = 32'h24; i_req3 = 1; d_req3 = 1;
        ncomp = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (d_ready3 && ncomp < 4) begin comp_d[ncomp] = 1'b1; comp_edge[ncomp] = k; ncomp++; end
            if (i_ready3 && ncomp < 4) begin comp_d[ncomp] = 1'b0; comp_edge[ncomp] = k; ncomp++; end
        end
        i_req3 = 0; d_req3 = 0;
        check_eq("l3_count", ncomp, 4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("l3_order%0d", k), 32'(comp_d[k]), 32'((k % 2) == 0));
            check_eq($sformatf("l3_edge%0d", k), comp_edge[k], 6 * (k + 1));
        end
        check_eq("l3_i_data", i_rdata3, 32'h20080005);
        check_eq("l3_d_data", d_rdata3, 32'h00000055);
        check_eq("l3_conflict", 32'(conflict_cnt3) - c0, 21);

        // reset during the wait cycle of a load
        repeat (2) @(negedge clk);
        dr0 = dr_cnt;
        d_addr = 32'h4; d_we = 0; d_req = 1;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_flags", 32'({i_ready, d_ready, d_err, ram_en, ram_we}), 32'h0);
        check_eq("mid_rst_rdata", d_rdata, 32'h0);
        check_eq("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
        d_req = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_eq("mid_rst_no_dready", dr_cnt - dr0, 0);
        check_eq("mid_rst_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        i_addr = 32'h8; i_req = 1;
        wait_ready(0, 20, e);
        i_req = 0;
        check_eq("post_rst_lat", e, 4);
        check_eq("post_rst_data", i_rdata, 32'h0000ABCD);

        check_eq("ram_idle_zero", bad_ram_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
